// File: rtl/custom_ring_counter_param.sv
// Programmable ring/one-shot counter with prescaler, synchronous clear and busy flag.
// Optional wrap counter output is enabled by defining CUSTOM_RING_COUNTER_WRAP_CNT_EN.
module custom_ring_counter_param #(
    parameter int CNT_WIDTH = 8,
    parameter int PRE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clear,
    input  logic [CNT_WIDTH-1:0] i_num_cnt,
    input  logic [1:0]           i_mode,
    input  logic [PRE_WIDTH-1:0] i_prescale,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 done_o,
    output logic                 busy_o,
`ifdef CUSTOM_RING_COUNTER_WRAP_CNT_EN
    output logic [7:0]           wrap_cnt_o,
`endif
    output logic [1:0]           state_o
);

    // Handshake: en is a level request; the count runs while en stays high and
    // done_o reports completion (level in one-shot, 1-cycle pulse per lap in ring
    // mode). Dropping en returns the block to IDLE on the next edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic [PRE_WIDTH-1:0] pre_q, pre_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [1:0]           mode_q, mode_d;
    logic [PRE_WIDTH-1:0] psc_q, psc_d;
`ifdef CUSTOM_RING_COUNTER_WRAP_CNT_EN
    logic [7:0]           wrap_q, wrap_d;
`endif

    logic                 tick;
    logic [CNT_WIDTH-1:0] start_val;
    logic [CNT_WIDTH-1:0] term_val;
    logic [CNT_WIDTH-1:0] step_val;

    // mode bit 1 selects down counting, bit 0 selects auto-reload
    assign tick      = (pre_q == psc_q);
    assign start_val = mode_q[1] ? num_q : '0;
    assign term_val  = mode_q[1] ? '0 : num_q;
    assign step_val  = mode_q[1] ? (cnt_q - 1'b1) : (cnt_q + 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pre_q   <= '0;
            num_q   <= '0;
            mode_q  <= '0;
            psc_q   <= '0;
`ifdef CUSTOM_RING_COUNTER_WRAP_CNT_EN
            wrap_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pre_q   <= pre_d;
            num_q   <= num_d;
            mode_q  <= mode_d;
            psc_q   <= psc_d;
`ifdef CUSTOM_RING_COUNTER_WRAP_CNT_EN
            wrap_q  <= wrap_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pre_d   = pre_q;
        num_d   = num_q;
        mode_d  = mode_q;
        psc_d   = psc_q;
`ifdef CUSTOM_RING_COUNTER_WRAP_CNT_EN
        wrap_d  = wrap_q;
`endif
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            pre_d   = '0;
`ifdef CUSTOM_RING_COUNTER_WRAP_CNT_EN
            wrap_d  = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        num_d  = i_num_cnt;
                        mode_d = i_mode;
                        psc_d  = i_prescale;
                        pre_d  = '0;
                        if (i_num_cnt != '0) begin
                            state_d = RUN;
                            cnt_d   = i_mode[1] ? i_num_cnt : '0;
                            done_d  = 1'b0;
`ifdef CUSTOM_RING_COUNTER_WRAP_CNT_EN
                            wrap_d  = '0;
`endif
                        end else begin
                            // zero-length count completes immediately
                            state_d = DONE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        pre_d   = '0;
                    end else begin
                        done_d = 1'b0;
                        if (tick) begin
                            pre_d = '0;
                            if (cnt_q == term_val) begin
                                // only reachable in ring mode: reload step
                                cnt_d = start_val;
`ifdef CUSTOM_RING_COUNTER_WRAP_CNT_EN
                                if (wrap_q != 8'hFF) begin
                                    wrap_d = wrap_q + 8'd1;
                                end
`endif
                            end else begin
                                cnt_d = step_val;
                                if (step_val == term_val) begin
                                    done_d = 1'b1;
                                    if (!mode_q[0]) begin
                                        state_d = DONE;
                                    end
                                end
                            end
                        end else begin
                            pre_d = pre_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!en) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    pre_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_o      = cnt_q;
        done_o     = done_q;
        busy_o     = (state_q == RUN);
        state_o    = state_q;
`ifdef CUSTOM_RING_COUNTER_WRAP_CNT_EN
        wrap_cnt_o = wrap_q;
`endif
    end

endmodule

// File: tb/tb_custom_ring_counter_param.sv
// Self-checking bench for custom_ring_counter_param: arithmetic reference model,
// per-cycle expected queue, and directed scenarios with literal checkpoints.
module tb_custom_ring_counter_param;

    localparam int CNT_WIDTH = 8;
    localparam int PRE_WIDTH = 4;
    localparam int W         = CNT_WIDTH + 2;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic                 clear;
    logic [CNT_WIDTH-1:0] i_num_cnt;
    logic [1:0]           i_mode;
    logic [PRE_WIDTH-1:0] i_prescale;
    logic [CNT_WIDTH-1:0] cnt_o;
    logic                 done_o;
    logic                 busy_o;
    logic [1:0]           state_o;
`ifdef CUSTOM_RING_COUNTER_WRAP_CNT_EN
    logic [7:0]           wrap_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    custom_ring_counter_param #(
        .CNT_WIDTH(CNT_WIDTH),
        .PRE_WIDTH(PRE_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clear      (clear),
        .i_num_cnt  (i_num_cnt),
        .i_mode     (i_mode),
        .i_prescale (i_prescale),
        .cnt_o      (cnt_o),
        .done_o     (done_o),
        .busy_o     (busy_o),
`ifdef CUSTOM_RING_COUNTER_WRAP_CNT_EN
        .wrap_cnt_o (wrap_cnt_o),
`endif
        .state_o    (state_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // reference model: phase 0 idle, 1 run, 2 done; m_e = clocks since start
    int m_phase, m_e, m_n, m_p, m_wrap;
    bit m_auto, m_down;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_e = 0; m_n = 0; m_p = 0; m_wrap = 0;
            m_auto = 0; m_down = 0;
        end else if (clear) begin
            m_phase = 0;
            m_wrap  = 0;
        end else begin
            case (m_phase)
                0: if (en) begin
                    m_n = int'(i_num_cnt);
                    m_p = int'(i_prescale);
                    m_auto = i_mode[0];
                    m_down = i_mode[1];
                    m_e = 0;
                    if (m_n != 0) begin
                        m_phase = 1;
                        m_wrap  = 0;
                    end else begin
                        m_phase = 2;
                    end
                end
                1: if (!en) begin
                    m_phase = 0;
                end else begin
                    m_e++;
                    if (!m_auto && (m_e / (m_p + 1)) >= m_n) m_phase = 2;
                    if (m_auto) begin
                        m_wrap = (m_e / (m_p + 1)) / (m_n + 1);
                        if (m_wrap > 255) m_wrap = 255;
                    end
                end
                default: if (!en) m_phase = 0;
            endcase
        end
    end

    logic [W-1:0] exp_q[$];

    always @(posedge clk) begin
        int steps, pos, ec, ed, eb;
        #1;
        ec = 0; ed = 0; eb = 0;
        steps = m_e / (m_p + 1);
        if (m_phase == 2) begin
            ec = m_down ? 0 : m_n;
            ed = 1;
        end else if (m_phase == 1) begin
            eb = 1;
            if (!m_auto) begin
                ec = m_down ? (m_n - steps) : steps;
            end else begin
                pos = steps % (m_n + 1);
                ec  = m_down ? (m_n - pos) : pos;
                ed  = (pos == m_n && (m_e % (m_p + 1)) == 0) ? 1 : 0;
            end
        end
        exp_q.push_back({ec[CNT_WIDTH-1:0], ed[0], eb[0]});
    end

    // scoreboard compare, every cycle
    always @(posedge clk) begin
        logic [W-1:0] e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("model_cnt",  int'(cnt_o),  int'(e[W-1:2]));
            check("model_done", int'(done_o), int'(e[1]));
            check("model_busy", int'(busy_o), int'(e[0]));
`ifdef CUSTOM_RING_COUNTER_WRAP_CNT_EN
            check("model_wrap", int'(wrap_cnt_o), m_wrap);
`endif
        end
    end

    // driver tasks; start_run returns just after edge k
    task automatic start_run(input logic [CNT_WIDTH-1:0] n, input logic [PRE_WIDTH-1:0] p,
                             input logic [1:0] mode);
        @(negedge clk);
        i_num_cnt  = n;
        i_prescale = p;
        i_mode     = mode;
        en         = 1'b1;
        @(posedge clk);
    endtask

    task automatic stop_run();
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #2;
        check("stop_cnt",  int'(cnt_o),  0);
        check("stop_done", int'(done_o), 0);
        check("stop_busy", int'(busy_o), 0);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; clear = 1'b0;
        i_num_cnt = '0; i_mode = '0; i_prescale = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_cnt",  int'(cnt_o),  0);
        check("reset_done", int'(done_o), 0);
        check("reset_busy", int'(busy_o), 0);
        @(negedge clk);
        rst = 1'b1;
        wait_edges(2);

        // up one-shot N=30 P=0, inputs changed in DONE must not matter
        start_run(8'd30, 4'd0, 2'b00);
        wait_edges(29);
        check("up_k29_cnt",  int'(cnt_o),  29);
        check("up_k29_done", int'(done_o), 0);
        wait_edges(1);
        check("up_k30_cnt",  int'(cnt_o),  30);
        check("up_k30_done", int'(done_o), 1);
        check("up_k30_busy", int'(busy_o), 0);
        @(negedge clk);
        i_num_cnt = 8'd99;
        wait_edges(3);
        check("up_hold_cnt", int'(cnt_o), 30);
        stop_run();

        // down one-shot N=60 P=2 with inputs changed mid-run
        start_run(8'd60, 4'd2, 2'b10);
        wait_edges(3);
        check("dn_k3_cnt", int'(cnt_o), 59);
        @(negedge clk);
        i_num_cnt = 8'd7; i_prescale = 4'd0; i_mode = 2'b01;
        wait_edges(176);
        check("dn_k179_cnt",  int'(cnt_o),  1);
        check("dn_k179_done", int'(done_o), 0);
        wait_edges(1);
        check("dn_k180_cnt",  int'(cnt_o),  0);
        check("dn_k180_done", int'(done_o), 1);
        stop_run();

        // up auto-reload N=5 P=0
        start_run(8'd5, 4'd0, 2'b01);
        wait_edges(5);
        check("ring_k5_done", int'(done_o), 1);
        check("ring_k5_cnt",  int'(cnt_o),  5);
        wait_edges(1);
        check("ring_k6_done", int'(done_o), 0);
        check("ring_k6_cnt",  int'(cnt_o),  0);
        wait_edges(5);
        check("ring_k11_done", int'(done_o), 1);
        wait_edges(6);
        check("ring_k17_done", int'(done_o), 1);
        check("ring_k17_busy", int'(busy_o), 1);
        wait_edges(3);
        stop_run();

        // down auto-reload with prescale, covered by the model
        start_run(8'd4, 4'd1, 2'b11);
        wait_edges(25);
        stop_run();

        // abort at cnt 12
        start_run(8'd30, 4'd0, 2'b00);
        wait_edges(12);
        check("abort_pre_cnt", int'(cnt_o), 12);
        stop_run();

        // clear at cnt 7 with en held, then release restarts
        start_run(8'd30, 4'd0, 2'b00);
        wait_edges(7);
        check("clr_pre_cnt", int'(cnt_o), 7);
        @(negedge clk);
        clear = 1'b1;
        wait_edges(1);
        check("clr_cnt",  int'(cnt_o),  0);
        check("clr_busy", int'(busy_o), 0);
        wait_edges(2);
        check("clr_hold_busy", int'(busy_o), 0);
        @(negedge clk);
        clear = 1'b0;
        wait_edges(1);
        check("clr_restart_busy", int'(busy_o), 1);
        wait_edges(3);
        check("clr_restart_cnt", int'(cnt_o), 3);
        stop_run();

        // clear beats a simultaneous terminal tick
        start_run(8'd3, 4'd0, 2'b00);
        wait_edges(2);
        @(negedge clk);
        clear = 1'b1;
        wait_edges(1);
        check("clr_term_done", int'(done_o), 0);
        check("clr_term_cnt",  int'(cnt_o),  0);
        @(negedge clk);
        clear = 1'b0;
        stop_run();

        // N=0 completes on the first edge
        start_run(8'd0, 4'd3, 2'b00);
        #2;
        check("zero_done", int'(done_o), 1);
        check("zero_cnt",  int'(cnt_o),  0);
        check("zero_busy", int'(busy_o), 0);
        stop_run();

        // full-range count
        start_run(8'd255, 4'd0, 2'b00);
        wait_edges(254);
        check("max_k254_cnt",  int'(cnt_o),  254);
        check("max_k254_done", int'(done_o), 0);
        wait_edges(1);
        check("max_k255_cnt",  int'(cnt_o),  255);
        check("max_k255_done", int'(done_o), 1);
        wait_edges(2);
        check("max_hold_cnt", int'(cnt_o), 255);
        stop_run();

        // asynchronous reset mid-run
        start_run(8'd20, 4'd0, 2'b00);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_cnt",  int'(cnt_o),  0);
        check("arst_busy", int'(busy_o), 0);
        check("arst_done", int'(done_o), 0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wait_edges(2);
        check("arst_idle_busy", int'(busy_o), 0);

`ifdef CUSTOM_RING_COUNTER_WRAP_CNT_EN
        start_run(8'd3, 4'd0, 2'b01);
        wait_edges(19);
        check("wrap_count", int'(wrap_cnt_o), 4);
        @(negedge clk);
        clear = 1'b1;
        wait_edges(1);
        check("wrap_clear", int'(wrap_cnt_o), 0);
        @(negedge clk);
        clear = 1'b0;
        en    = 1'b0;
        wait_edges(2);
`endif

        wait_edges(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
